weight_fifo_loader: RTL and testbench



---
 rtl/weight_buf_pkg.sv | 27 ++
 rtl/weight_bank_tracker.sv | 46 ++++
 rtl/weight_fifo_loader.sv | 185 ++++++++++++++++++
 tb/tb_weight_fifo_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buf_pkg.sv
// rtl/weight_buf_pkg.sv - shared types and helpers for the weight buffer loader
// Contents: NUM_BANKS, FSM state encoding (state_t), clogb2 width helper.
package weight_buf_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BANK = 2'd1,
        LOAD      = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Number of bits needed to represent value (clogb2(511) = 9).
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/weight_bank_tracker.sv
// rtl/weight_bank_tracker.sv - ping-pong bank ownership flags and target pointer
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_ready         pulse: mark target bank loaded and advance to the other bank
//   bank_release[b]   pulse from compute handing bank b back to the loader
//   bank_ready[b]     bank b loaded and owned by compute
//   tgt_bank          bank the next load writes into
module weight_bank_tracker
    import weight_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_ready,
    input  logic [NUM_BANKS-1:0] bank_release,
    output logic [NUM_BANKS-1:0] bank_ready,
    output logic                 tgt_bank
);

    logic [NUM_BANKS-1:0] ready_q, ready_d;
    logic                 tgt_q, tgt_d;

    always_comb begin
        // Release of a bank that is not ready leaves it clear, so no extra
        // qualification is needed; the set below overrides a same-cycle release.
        ready_d = ready_q & ~bank_release;
        tgt_d   = tgt_q;
        if (set_ready) begin
            ready_d[tgt_q] = 1'b1;
            tgt_d          = ~tgt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= '0;
            tgt_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bank_ready = ready_q;
    assign tgt_bank   = tgt_q;

endmodule

// File: rtl/weight_fifo_loader.sv
// rtl/weight_fifo_loader.sv - pops weight words from a show-ahead FIFO into a ping-pong bank
// Optional feature macro: WEIGHT_FIFO_LOADER_CHECKSUM_EN (adds checksum output).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   weights, weight_empty       FIFO head word and empty flag
//   weight_req                  pop request (pop on edge with weight_req && !weight_empty)
//   start, load_len             load command and word count (clipped to BUF_DEPTH)
//   busy, done                  not-idle flag, one-cycle end-of-load pulse
//   wr_en/wr_bank/wr_addr/wr_data  registered buffer write port
//   checksum                    XOR of words written in the current load (macro only)
//   bank_ready, bank_release    bank ownership handshake with compute
module weight_fifo_loader
    import weight_buf_pkg::*;
#(
    parameter int DATA_LEN  = 64,
    parameter int BUF_DEPTH = 512,
    parameter int ADDR_W    = clogb2(BUF_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_LEN-1:0]  weights,
    input  logic                 weight_empty,
    output logic                 weight_req,
    input  logic                 start,
    input  logic [ADDR_W:0]      load_len,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_en,
    output logic                 wr_bank,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_LEN-1:0]  wr_data,
`ifdef WEIGHT_FIFO_LOADER_CHECKSUM_EN
    output logic [DATA_LEN-1:0]  checksum,
`endif
    output logic [NUM_BANKS-1:0] bank_ready,
    input  logic [NUM_BANKS-1:0] bank_release
);

    localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t                state_q, state_d;
    logic [ADDR_W:0]       rem_q, rem_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  load_nz_q, load_nz_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_LEN-1:0]   wr_data_q, wr_data_d;

    logic                  pop;
    logic                  set_ready;
    logic                  tgt_bank;
    logic [ADDR_W:0]       clipped_len;

    weight_bank_tracker u_bank_tracker (
        .clk          (clk),
        .rst          (rst),
        .set_ready    (set_ready),
        .bank_release (bank_release),
        .bank_ready   (bank_ready),
        .tgt_bank     (tgt_bank)
    );

    always_comb begin
        clipped_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;
        pop         = (state_q == LOAD) && !weight_empty && (rem_q != '0);

        state_d   = state_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        load_nz_d = load_nz_q;
        wr_en_d   = pop;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d     = clipped_len;
                    addr_d    = '0;
                    load_nz_d = (clipped_len != '0);
                    // A zero-length load writes nothing, so it needs no bank
                    // ownership: it passes through one empty LOAD cycle to DONE.
                    if (clipped_len == '0) begin
                        state_d = LOAD;
                    end else if (bank_ready[tgt_bank]) begin
                        state_d = WAIT_BANK;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            WAIT_BANK: begin
                if (!bank_ready[tgt_bank] || bank_release[tgt_bank]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (pop) begin
                    rem_d  = rem_q - REM_ONE;
                    addr_d = addr_q + ADDR_ONE;
                end
                if ((rem_q == '0) || (pop && (rem_q == REM_ONE))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Write port captures the popped head word; one cycle pop-to-write.
        if (pop) begin
            wr_bank_d = tgt_bank;
            wr_addr_d = addr_q;
            wr_data_d = weights;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            addr_q    <= '0;
            load_nz_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            load_nz_q <= load_nz_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Bank hand-over happens in the DONE cycle, alongside the final write.
    assign set_ready  = (state_q == DONE) && load_nz_q;
    assign weight_req = pop;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign wr_en      = wr_en_q;
    assign wr_bank    = wr_bank_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

`ifdef WEIGHT_FIFO_LOADER_CHECKSUM_EN
    logic [DATA_LEN-1:0] checksum_q, checksum_d;

    // Accumulating on pop makes the sum complete in the DONE cycle, when the
    // last word is still in the write register.
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == IDLE) && start) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q ^ weights;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    // Checksum datapath not built in this configuration.
`endif

endmodule

// File: tb/tb_weight_fifo_loader.sv
// tb/tb_weight_fifo_loader.sv - directed table-driven bench for weight_fifo_loader
module tb_weight_fifo_loader;

    localparam int DATA_LEN  = 64;
    localparam int BUF_DEPTH = 512;
    localparam int ADDR_W    = 9;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATA_LEN-1:0] weights;
    logic                weight_empty;
    logic                weight_req;
    logic                start;
    logic [ADDR_W:0]     load_len;
    logic                busy;
    logic                done;
    logic                wr_en;
    logic                wr_bank;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_LEN-1:0] wr_data;
    logic [1:0]          bank_ready;
    logic [1:0]          bank_release;
`ifdef WEIGHT_FIFO_LOADER_CHECKSUM_EN
    logic [DATA_LEN-1:0] checksum;
`endif

    weight_fifo_loader #(
        .DATA_LEN  (DATA_LEN),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .weights      (weights),
        .weight_empty (weight_empty),
        .weight_req   (weight_req),
        .start        (start),
        .load_len     (load_len),
        .busy         (busy),
        .done         (done),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
`ifdef WEIGHT_FIFO_LOADER_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .bank_ready   (bank_ready),
        .bank_release (bank_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        bit         stall;
        logic [1:0] rel;
        int         exp_writes;
        logic       exp_bank;
        logic [1:0] exp_ready;
        int         exp_done_cyc;
    } vec_t;

    vec_t vecs[4];

    logic [63:0] fifo[$];
    int          log_addr[$];
    logic [63:0] log_data[$];
    logic        log_bank[$];

    int          n_pass = 0;
    int          n_total = 0;
    bit          stall = 0;
    bit          stall_mode = 0;
    bit          pop_ok;
    int          cyc_cnt, done_cyc, n_done, req_viol;
    bit          done_wr;
    logic        snap_busy, snap_done, snap_wr_en, snap_wr_bank, snap_req;
    logic [ADDR_W-1:0] snap_wr_addr;
    logic [63:0] snap_wr_data;
    logic [1:0]  snap_ready;
    logic [63:0] snap_cks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] word(input logic [7:0] tag, input int i);
        return {tag, 24'd0, 32'(i)};
    endfunction

    task automatic drive_fifo();
        weight_empty = stall || (fifo.size() == 0);
        weights      = (fifo.size() != 0) ? fifo[0] : 64'd0;
    endtask

    // One clock: pop decision just before the edge, input update after it,
    // output snapshot at the falling edge.
    task automatic cycle();
        #1;
        pop_ok = weight_req && !weight_empty;
        @(posedge clk);
        #1;
        if (pop_ok && fifo.size() != 0) void'(fifo.pop_front());
        start        = 1'b0;
        bank_release = 2'b00;
        if (stall_mode) stall = ~stall;
        drive_fifo();
        @(negedge clk);
        cyc_cnt++;
        snap_busy    = busy;
        snap_done    = done;
        snap_wr_en   = wr_en;
        snap_wr_bank = wr_bank;
        snap_wr_addr = wr_addr;
        snap_wr_data = wr_data;
        snap_ready   = bank_ready;
        snap_req     = weight_req;
        if (weight_req && weight_empty) req_viol++;
        if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(wr_data);
            log_bank.push_back(wr_bank);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_cnt;
            done_wr  = wr_en;
`ifdef WEIGHT_FIFO_LOADER_CHECKSUM_EN
            snap_cks = checksum;
`else
            snap_cks = 64'd0;
`endif
        end
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        log_bank.delete();
        n_done   = 0;
        done_cyc = -1;
        done_wr  = 0;
        req_viol = 0;
        cyc_cnt  = 0;
    endtask

    task automatic load_words(input logic [7:0] tag, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(word(tag, i));
        drive_fifo();
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 1000 && done_cyc < 0; k++) cycle();
        chk({name, "_finished"}, (done_cyc >= 0), 1);
    endtask

    task automatic run_load(input int len, input string name);
        clear_logs();
        load_len = len[ADDR_W:0];
        start    = 1'b1;
        wait_done(name);
    endtask

    task automatic check_words(input string name, input logic [7:0] tag, input int n, input logic bank);
        int errs;
        errs = 0;
        chk({name, "_nwrites"}, log_addr.size(), n);
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] != i || log_data[i] !== word(tag, i) || log_bank[i] !== bank) errs++;
        end
        chk({name, "_word_errs"}, errs, 0);
    endtask

    task automatic apply_vec(input int idx);
        vec_t  v;
        string name;
        logic [7:0] tag;
        v    = vecs[idx];
        name = $sformatf("vec%0d", idx);
        tag  = 8'(8'hA0 + idx);
        if (v.rel != 2'b00) begin
            bank_release = v.rel;
            cycle();
        end
        load_words(tag, v.exp_writes + 2);
        stall_mode = v.stall;
        run_load(v.len, name);
        stall_mode = 0;
        stall      = 0;
        drive_fifo();
        check_words(name, tag, v.exp_writes, v.exp_bank);
        if (v.exp_done_cyc >= 0) chk({name, "_done_cyc"}, done_cyc, v.exp_done_cyc);
        if (v.exp_writes > 0) begin
            chk({name, "_done_with_last_wr"}, done_wr, 1);
            if (log_addr.size() > 0) chk({name, "_last_addr"}, log_addr[log_addr.size()-1], v.exp_writes - 1);
        end
        chk({name, "_req_when_empty"}, req_viol, 0);
        cycle();
        chk({name, "_done_one_pulse"}, snap_done, 0);
        chk({name, "_idle_after"}, snap_busy, 0);
        chk({name, "_bank_ready"}, snap_ready, v.exp_ready);
        chk({name, "_fifo_left"}, fifo.size(), 2);
        fifo.delete();
        drive_fifo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nreq;
        //            len  stall rel    writes bank ready  done_cyc
        vecs[0] = '{8,   1'b0, 2'b00, 8,   1'b0, 2'b01, 9};
        vecs[1] = '{4,   1'b1, 2'b00, 4,   1'b1, 2'b11, -1};
        vecs[2] = '{0,   1'b0, 2'b00, 0,   1'b0, 2'b11, 2};
        vecs[3] = '{517, 1'b0, 2'b10, 512, 1'b1, 2'b11, 513};

        rst          = 1'b1;
        start        = 1'b0;
        load_len     = '0;
        bank_release = 2'b00;
        drive_fifo();
        clear_logs();
        cycle();
        cycle();
        chk("rst_busy", snap_busy, 0);
        chk("rst_done", snap_done, 0);
        chk("rst_wr_en", snap_wr_en, 0);
        chk("rst_wr_bank", snap_wr_bank, 0);
        chk("rst_wr_addr", snap_wr_addr, 0);
        chk("rst_wr_data", snap_wr_data, 0);
        chk("rst_bank_ready", snap_ready, 2'b00);
        rst = 1'b0;
        cycle();

        apply_vec(0);
        apply_vec(1);

        // Both banks owned by compute: the next load must wait for a release.
        load_words(8'h33, 5);
        clear_logs();
        load_len = 10'd3;
        start    = 1'b1;
        cycle();
        chk("wait_busy", snap_busy, 1);
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            if (snap_req) nreq++;
            cycle();
        end
        chk("wait_no_req", nreq, 0);
        chk("wait_no_write", log_addr.size(), 0);
        bank_release = 2'b01;
        cycle();
        chk("wait_released_ready", snap_ready, 2'b10);
        wait_done("wait");
        check_words("wait", 8'h33, 3, 1'b0);
        cycle();
        chk("wait_bank_ready", snap_ready, 2'b11);
        fifo.delete();
        drive_fifo();

        apply_vec(2);
        apply_vec(3);

        // Reset in the middle of a load.
        bank_release = 2'b01;
        cycle();
        load_words(8'h55, 8);
        clear_logs();
        load_len = 10'd8;
        start    = 1'b1;
        for (int k = 0; k < 50 && log_addr.size() < 3; k++) cycle();
        chk("midrst_three_writes", log_addr.size(), 3);
        rst = 1'b1;
        cycle();
        chk("midrst_busy", snap_busy, 0);
        chk("midrst_wr_en", snap_wr_en, 0);
        chk("midrst_bank_ready", snap_ready, 2'b00);
        chk("midrst_wr_bank", snap_wr_bank, 0);
        rst = 1'b0;
        cycle();
        chk("postrst_wr_en", snap_wr_en, 0);
        chk("postrst_req", snap_req, 0);
        fifo.delete();
        load_words(8'h66, 2);
        run_load(2, "postrst");
        check_words("postrst", 8'h66, 2, 1'b0);
        cycle();
        chk("postrst_bank_ready", snap_ready, 2'b01);

`ifdef WEIGHT_FIFO_LOADER_CHECKSUM_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        fifo.delete();
        fifo.push_back(64'hF0);
        fifo.push_back(64'h0F);
        fifo.push_back(64'hFF);
        drive_fifo();
        run_load(3, "cks1");
        chk("cks1_value", snap_cks, 64'h00);
        cycle();
        fifo.push_back(64'hAA);
        drive_fifo();
        run_load(1, "cks2");
        chk("cks2_value", snap_cks, 64'hAA);
        cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
